// File: rtl/feedback_tone_player_pkg.sv
// -----------------------------------------------------------------------------
// feedback_pkg
// Shared definitions for the feedback tone player: note codes carried on the
// 3-bit feedback address stream, the pitch of each code, and a helper that
// turns a code into the divider half-period for a given system clock.
// No ports (package).
// -----------------------------------------------------------------------------
package feedback_pkg;

   // Note codes emitted by the game controller
   localparam logic [2:0] NOTE_OFF = 3'd0;
   localparam logic [2:0] NOTE_C5  = 3'd1;
   localparam logic [2:0] NOTE_E5  = 3'd2;
   localparam logic [2:0] NOTE_G5  = 3'd3;
   localparam logic [2:0] NOTE_ERR = 3'd4;
   localparam logic [2:0] NOTE_C6  = 3'd5;

   // Pitch of each note in Hz
   localparam int unsigned FREQ_C5  = 523;
   localparam int unsigned FREQ_E5  = 659;
   localparam int unsigned FREQ_G5  = 784;
   localparam int unsigned FREQ_ERR = 220;
   localparam int unsigned FREQ_C6  = 1047;

   // Width of the value returned by half_period
   localparam int HP_W = 20;

   // Frequency of a code; 0 for silence and for the reserved codes 6 and 7
   function automatic int unsigned note_freq(input logic [2:0] code);
      int unsigned f;
      case (code)
         NOTE_C5:  f = FREQ_C5;
         NOTE_E5:  f = FREQ_E5;
         NOTE_G5:  f = FREQ_G5;
         NOTE_ERR: f = FREQ_ERR;
         NOTE_C6:  f = FREQ_C6;
         default:  f = 0;
      endcase
      return f;
   endfunction

   // True for codes that produce an audible tone
   function automatic logic is_sounding(input logic [2:0] code);
      return note_freq(code) != 0;
   endfunction

   // Divider half-period in clk cycles: clk_hz / (2*f), truncated; 0 for silence
   function automatic logic [HP_W-1:0] half_period(input logic [2:0] code,
                                                   input int unsigned clk_hz);
      int unsigned f;
      f = note_freq(code);
      if (f == 0) begin
         return '0;
      end
      return HP_W'(clk_hz / (32'd2 * f));
   endfunction

endpackage

// File: rtl/feedback_tone_player_if.sv
// -----------------------------------------------------------------------------
// feedback_tone_player_if
// Bundles the feedback address stream coming from the game controller with the
// buzzer/status outputs going to the board pins.
//   slow_clk : slow tick level from the index generator (master -> slave)
//   address  : 3-bit note code, sampled on each slow tick (master -> slave)
//   buzzer   : square-wave drive to the piezo (slave -> master)
//   playing  : high while an audible note is sounding (slave -> master)
//   note     : currently latched note code (slave -> master)
//   seq_done : one-clk pulse at the end of a feedback sequence (slave -> master)
// -----------------------------------------------------------------------------
interface feedback_tone_player_if;
   logic       slow_clk;
   logic [2:0] address;
   logic       buzzer;
   logic       playing;
   logic [2:0] note;
   logic       seq_done;

   modport master (
      output slow_clk, address,
      input  buzzer, playing, note, seq_done
   );

   modport slave (
      input  slow_clk, address,
      output buzzer, playing, note, seq_done
   );
endinterface

// File: rtl/feedback_tone_player_tone_divider.sv
// -----------------------------------------------------------------------------
// tone_divider
// Square-wave generator: counts 0..half-1 and toggles the buzzer on each wrap,
// giving a period of 2*half clk cycles. Held silent (counter and output at 0)
// whenever it is not enabled; clear restarts it from a low output.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clear  : restart counter and force output low (has priority)
//   enable : run the divider
//   half   : half-period in clk cycles (must be >= 1 while enabled)
//   buzzer : square-wave output
// -----------------------------------------------------------------------------
module tone_divider #(
   parameter int DIV_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] half,
   output logic             buzzer
);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         buzzer  <= 1'b0;
      end else if (clear || !enable) begin
         div_cnt <= '0;
         buzzer  <= 1'b0;
      end else if (div_cnt == half - 1'b1) begin
         div_cnt <= '0;
         buzzer  <= ~buzzer;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/feedback_tone_player.sv
// -----------------------------------------------------------------------------
// feedback_tone_player
// Plays the note selected by each feedback address on a piezo buzzer. The slow
// tick is synchronized and edge-detected; each tick latches a new note, and a
// nonzero note repeated on consecutive ticks is preceded by a silent gap so the
// two beeps are heard separately. seq_done pulses when a sounding note is
// followed by the silence code.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of feedback_tone_player_if
//           (slow_clk, address in; buzzer, playing, note, seq_done out)
// -----------------------------------------------------------------------------
module feedback_tone_player
   import feedback_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int GAP_CYCLES = 2_500_000,
   parameter int DIV_W      = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   feedback_tone_player_if.slave  bus
);

   localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

   logic             sync_p0, sync_p1, edge_p2, tick_p3;
   logic             fill_p0, fill_p1, armed;
   logic [2:0]       note_q, note_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic             playing_q, seq_done_q;
   logic [DIV_W-1:0] half;
   logic             div_en;
   logic             buzzer_w;

   // Stage p0/p1: two-flop synchronizer for the slow tick level.
   // Stage p2/p3: delayed copy for edge detection, then the registered tick.
   // fill_p* marks when sync_p1 holds a real sample after reset; armed is set
   // once slow_clk has been seen low, so a level already high at reset release
   // does not count as a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         edge_p2 <= 1'b0;
         tick_p3 <= 1'b0;
         fill_p0 <= 1'b0;
         fill_p1 <= 1'b0;
         armed   <= 1'b0;
      end else begin
         sync_p0 <= bus.slow_clk;
         sync_p1 <= sync_p0;
         edge_p2 <= sync_p1;
         tick_p3 <= armed & sync_p1 & ~edge_p2;
         fill_p0 <= 1'b1;
         fill_p1 <= fill_p0;
         armed   <= armed | (fill_p1 & ~sync_p1);
      end
   end

   // Next note and gap state. A tick always overrides a running gap: it either
   // reloads it (same nonzero note again) or clears it.
   always_comb begin
      note_nxt = note_q;
      gap_nxt  = gap_cnt;
      if (tick_p3) begin
         note_nxt = bus.address;
         if (bus.address == note_q && bus.address != NOTE_OFF) begin
            gap_nxt = GAP_W'(GAP_CYCLES);
         end else begin
            gap_nxt = '0;
         end
      end else if (gap_cnt != '0) begin
         gap_nxt = gap_cnt - 1'b1;
      end
   end

   // Note, gap and status registers; playing follows the next-state values so
   // it changes on the same edge as note and gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_q     <= NOTE_OFF;
         gap_cnt    <= '0;
         playing_q  <= 1'b0;
         seq_done_q <= 1'b0;
      end else begin
         note_q     <= note_nxt;
         gap_cnt    <= gap_nxt;
         playing_q  <= is_sounding(note_nxt) && (gap_nxt == '0);
         seq_done_q <= tick_p3 && is_sounding(note_q) && (bus.address == NOTE_OFF);
      end
   end

   assign half   = DIV_W'(half_period(note_q, CLK_HZ));
   assign div_en = is_sounding(note_q) && (gap_cnt == '0);

   tone_divider #(
      .DIV_W (DIV_W)
   ) u_tone_divider (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tick_p3),
      .enable (div_en),
      .half   (half),
      .buzzer (buzzer_w)
   );

   assign bus.buzzer   = buzzer_w;
   assign bus.playing  = playing_q;
   assign bus.note     = note_q;
   assign bus.seq_done = seq_done_q;

endmodule
